// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters and the register-file write arbiter.
// The master side drives write requests. The slave side owns the buffers and the write port.
interface regfile_wb_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      reg_wr;
    logic [ADDR_W-1:0]         waddr;
    logic [DATA_W-1:0]         wdata;
    logic [(2**ADDR_W)-1:0]    pending_mask;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, reg_wr, waddr, wdata, pending_mask
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, reg_wr, waddr, wdata, pending_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares one register-file write port between NUM_REQ writeback
// sources. Each source has a one-entry buffer. Each cycle the arbiter drains one buffer.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave wb
);
    localparam int unsigned LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NREG = 2**ADDR_W;

    logic [NUM_REQ-1:0] buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0]  buf_addr_q [NUM_REQ];
    logic [ADDR_W-1:0]  buf_addr_d [NUM_REQ];
    logic [DATA_W-1:0]  buf_data_q [NUM_REQ];
    logic [DATA_W-1:0]  buf_data_d [NUM_REQ];
    logic [LG_W-1:0]    last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0] grant_c;
    logic [LG_W-1:0]    gidx_c;
    logic               gvalid_c;
    logic [NUM_REQ-1:0] ready_c;
    logic               reg_wr_c;
    logic [ADDR_W-1:0]  waddr_c;
    logic [DATA_W-1:0]  wdata_c;
    logic [NREG-1:0]    pending_c;

    // Round-robin search starting one past the previous grant
    always_comb begin
        int unsigned idx;
        grant_c  = '0;
        gidx_c   = '0;
        gvalid_c = 1'b0;
        idx      = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(last_grant_q) + off) % NUM_REQ;
            if (!gvalid_c && buf_valid_q[LG_W'(idx)]) begin
                gvalid_c = 1'b1;
                gidx_c   = LG_W'(idx);
            end
        end
        if (gvalid_c) begin
            grant_c[gidx_c] = 1'b1;
        end
    end

    // Write port, driven from the registered buffers only
    always_comb begin
        reg_wr_c = 1'b0;
        waddr_c  = '0;
        wdata_c  = '0;
        if (gvalid_c) begin
            waddr_c  = buf_addr_q[gidx_c];
            wdata_c  = buf_data_q[gidx_c];
            reg_wr_c = (buf_addr_q[gidx_c] != '0);
        end
    end

    // Readiness. Requests that would duplicate a pending nonzero destination are held off,
    // so two buffers never hold the same register. On a same-cycle tie the lower index goes first.
    always_comb begin
        logic [NUM_REQ-1:0] rdy;
        logic [NUM_REQ-1:0] waw;
        logic [ADDR_W-1:0]  addr_i;
        rdy    = '0;
        waw    = '0;
        addr_i = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_i = wb.req_addr[i*ADDR_W +: ADDR_W];
            if (addr_i != '0) begin
                for (int unsigned j = 0; j < NUM_REQ; j++) begin
                    if (j != i && buf_valid_q[j] && !grant_c[j] && buf_addr_q[j] == addr_i) begin
                        waw[i] = 1'b1;
                    end
                end
                for (int unsigned k = 0; k < i; k++) begin
                    if (wb.req_valid[k] && rdy[k] && wb.req_addr[k*ADDR_W +: ADDR_W] == addr_i) begin
                        waw[i] = 1'b1;
                    end
                end
            end
            rdy[i] = (!buf_valid_q[i] || grant_c[i]) && !waw[i] && !rst;
        end
        ready_c = rdy;
    end

    always_comb begin
        pending_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (buf_valid_q[i] && buf_addr_q[i] != '0) begin
                pending_c[buf_addr_q[i]] = 1'b1;
            end
        end
    end

    // Next state: the granted buffer drains, and an accepting buffer reloads
    always_comb begin
        buf_valid_d  = buf_valid_q & ~grant_c;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        last_grant_d = gvalid_c ? gidx_c : last_grant_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (wb.req_valid[i] && ready_c[i]) begin
                buf_valid_d[i] = 1'b1;
                buf_addr_d[i]  = wb.req_addr[i*ADDR_W +: ADDR_W];
                buf_data_d[i]  = wb.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q  <= '0;
            last_grant_q <= LG_W'(NUM_REQ - 1);
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                buf_addr_q[i] <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            buf_valid_q  <= buf_valid_d;
            last_grant_q <= last_grant_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
        end
    end

    assign wb.req_ready    = ready_c;
    assign wb.reg_wr       = reg_wr_c;
    assign wb.waddr        = waddr_c;
    assign wb.wdata        = wdata_c;
    assign wb.pending_mask = pending_c;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Expected register writes are queued in order.
// A negedge monitor compares every write the DUT makes against that queue.
module tb_regfile_wb_arbiter;
    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    wr_t  exp_q[$];

    regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Monitor: every write the register file would see must match the head of the queue
    always @(negedge clk) begin
        if (!rst && wb.reg_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, wb.waddr, wb.wdata}, 64'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("write_addr", 64'(wb.waddr), 64'(w.a));
                chk("write_data", 64'(wb.wdata), 64'(w.d));
            end
        end
    end

    // Slot = 1 time unit after the falling edge; outputs there describe the current cycle
    task automatic next_slot();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        wb.req_valid = {v1, v0};
        wb.req_addr  = {a1, a0};
        wb.req_data  = {d1, d0};
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        next_slot();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) next_slot();
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  er;
        logic [31:0] ka;
        logic [31:0] kb;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;

        // Reset holds everything at zero even with both requesters valid
        drive(1'b1, 5'd1, 32'h1111, 1'b1, 5'd2, 32'h2222);
        next_slot();
        next_slot();
        chk("rst_ready", 64'(wb.req_ready), 64'd0);
        chk("rst_reg_wr", 64'(wb.reg_wr), 64'd0);
        chk("rst_waddr", 64'(wb.waddr), 64'd0);
        chk("rst_wdata", 64'(wb.wdata), 64'd0);
        chk("rst_mask", 64'(wb.pending_mask), 64'd0);
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        chk("post_rst_ready", 64'(wb.req_ready), 64'h3);
        chk("post_rst_mask", 64'(wb.pending_mask), 64'd0);

        // Single write
        next_slot();
        push(5'd5, 32'hDEADBEEF);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        next_slot();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        chk("single_reg_wr", 64'(wb.reg_wr), 64'd1);
        chk("single_mask", 64'(wb.pending_mask), 64'h20);
        next_slot();
        chk("single_mask_clear", 64'(wb.pending_mask), 64'd0);
        chk("single_idle_wr", 64'(wb.reg_wr), 64'd0);
        wait_drain();

        // Contention: strict alternation, one write per cycle
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(5'd3, 32'hA000_0000 + 32'(k));
            push(5'd4, 32'hB000_0000 + 32'(k));
        end
        ka = 0;
        kb = 0;
        for (int c = 0; c < 7; c++) begin
            er = (c == 0) ? 2'b11 : ((c % 2 == 1) ? 2'b01 : 2'b10);
            drive(1'b1, 5'd3, 32'hA000_0000 + ka, 1'b1, 5'd4, 32'hB000_0000 + kb);
            chk("cont_ready", 64'(wb.req_ready), 64'(er));
            if (c > 0) chk("cont_one_per_cycle", 64'(wb.reg_wr), 64'd1);
            if (er[0]) ka++;
            if (er[1]) kb++;
            next_slot();
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        chk("cont_tail_wr0", 64'(wb.reg_wr), 64'd1);
        next_slot();
        chk("cont_tail_wr1", 64'(wb.reg_wr), 64'd1);
        wait_drain();

        // Same-address collision: lower index first, order preserved
        do_reset();
        push(5'd7, 32'd1);
        push(5'd7, 32'd2);
        drive(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
        chk("waw_ready_c0", 64'(wb.req_ready), 64'h1);
        next_slot();
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'd2);
        chk("waw_ready_c1", 64'(wb.req_ready), 64'h3);
        chk("waw_mask_c1", 64'(wb.pending_mask), 64'h80);
        next_slot();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        chk("waw_mask_c2", 64'(wb.pending_mask), 64'h80);
        next_slot();
        chk("waw_mask_c3", 64'(wb.pending_mask), 64'd0);
        wait_drain();

        // x0 write: granted but no register-file write
        do_reset();
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h55);
        chk("x0_ready", 64'(wb.req_ready), 64'h3);
        next_slot();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        chk("x0_reg_wr", 64'(wb.reg_wr), 64'd0);
        chk("x0_granted_wdata", 64'(wb.wdata), 64'h55);
        chk("x0_mask", 64'(wb.pending_mask), 64'd0);
        next_slot();
        chk("x0_idle_wdata", 64'(wb.wdata), 64'd0);

        // Reset between edges discards both buffered writes
        do_reset();
        drive(1'b1, 5'd10, 32'h111, 1'b1, 5'd11, 32'h222);
        chk("midrst_accept", 64'(wb.req_ready), 64'h3);
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        chk("midrst_mask_pre", 64'(wb.pending_mask), 64'hC00);
        rst = 1'b1;
        #1;
        chk("midrst_reg_wr", 64'(wb.reg_wr), 64'd0);
        chk("midrst_waddr", 64'(wb.waddr), 64'd0);
        chk("midrst_wdata", 64'(wb.wdata), 64'd0);
        chk("midrst_mask", 64'(wb.pending_mask), 64'd0);
        chk("midrst_ready", 64'(wb.req_ready), 64'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) next_slot();
        chk("midrst_after_mask", 64'(wb.pending_mask), 64'd0);
        chk("midrst_after_ready", 64'(wb.req_ready), 64'h3);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
